// File: rtl/gf2m_sqrt_iter.sv
// gf2m_sqrt_iter: iterative square root over GF(2^M) with reduction polynomial F.
// c = sqrt(a) = a^(2^(M-1)) mod F, computed by repeated squaring of a registered
// accumulator. Start/done handshake; c holds until the next accepted start.
// Optional build macro GF2M_SQRT_UNROLL2_EN: two squarer stages per step,
// which roughly halves the latency. The results are bit-identical to the single-stage build.
module gf2m_sqrt_iter #(
  parameter int            M = 163,
  parameter logic [M-1:0]  F = M'(8'hC9)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] a,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] c
);

  localparam int CW = $clog2(M);

`ifdef GF2M_SQRT_UNROLL2_EN
  // Two squarings per step: ceil((M-1)/2) steps. When M-1 is odd, the final step uses a single stage.
  localparam logic [CW-1:0] CNT_LOAD = CW'(M / 2);
  localparam logic          ODD      = ((M - 1) % 2) == 1;
`else
  localparam logic [CW-1:0] CNT_LOAD = CW'(M - 1);
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_reg, state_next;
  logic [M-1:0]   acc_reg, acc_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [M-1:0]   c_next;
  logic           busy_next, done_next;
  logic [M-1:0]   sq1, step;
`ifdef GF2M_SQRT_UNROLL2_EN
  logic [M-1:0]   sq2;
  logic           odd_reg, odd_next;
`endif

  // Field square: spread bits to even positions, then fold every term x^i (i >= M)
  // back down using x^M = F.
  function automatic logic [M-1:0] sq(input logic [M-1:0] x);
    logic [2*M-2:0] t;
    t = '0;
    for (int i = 0; i < M; i++) begin
      t[2*i] = x[i];
    end
    for (int i = 2*M-2; i >= M; i--) begin
      if (t[i]) begin
        t[i-M +: M] = t[i-M +: M] ^ F;
        t[i] = 1'b0;
      end
    end
    return t[M-1:0];
  endfunction

  // Squarer stage(s) applied to the accumulator.
  always_comb begin
    sq1 = sq(acc_reg);
`ifdef GF2M_SQRT_UNROLL2_EN
    sq2 = sq(sq1);
`endif
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    c_next     = c;
    busy_next  = busy;
    done_next  = 1'b0;
    step       = sq1;
`ifdef GF2M_SQRT_UNROLL2_EN
    odd_next   = odd_reg;
    step       = (odd_reg && (cnt_reg == CW'(1))) ? sq1 : sq2;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          acc_next   = a;
          cnt_next   = CNT_LOAD;
          busy_next  = 1'b1;
          state_next = RUN;
`ifdef GF2M_SQRT_UNROLL2_EN
          odd_next   = ODD;
`endif
        end
      end
      RUN: begin
        acc_next = step;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          c_next     = step;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      c         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef GF2M_SQRT_UNROLL2_EN
      odd_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      c         <= c_next;
      busy      <= busy_next;
      done      <= done_next;
`ifdef GF2M_SQRT_UNROLL2_EN
      odd_reg   <= odd_next;
`endif
    end
  end

endmodule
